// File: rtl/cmd_pkg.sv
// Shared command types and field constants for the mission command path
// (UART_wrapper -> cmd_queue -> command processor).
package cmd_pkg;

   typedef logic [15:0] cmd_t;

   localparam cmd_t FLUSH_CMD_DEF = 16'h0000;

   // Opcode lives in the top nibble; veer/turn carry a signed amount in the low byte.
   localparam int         OPC_MSB      = 15;
   localparam int         OPC_LSB      = 12;
   localparam logic [3:0] OPC_VEER     = 4'h1;
   localparam logic [3:0] OPC_TURN     = 4'h2;
   localparam int         VEER_AMT_MSB = 7;
   localparam int         VEER_AMT_LSB = 0;
   localparam int         TURN_DIR_BIT = 8;

   function automatic logic is_cmd(input cmd_t c, input cmd_t match);
      return c == match;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Circular command store with occupancy count and a flush port that collapses
// the queue to the single word being written.
module cmd_fifo
   import cmd_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  cmd_t          wdata,
   output cmd_t          head,
   output logic [CW-1:0] count
);

   cmd_t          mem [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          empty, full, do_pop, do_push;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign do_pop  = pop & ~empty & ~flush;
   // A same-cycle pop frees the slot the full queue would otherwise refuse.
   assign do_push = push & ~flush & (~full | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
         wr_ptr_d = wr_ptr_q + PW'(1);
         count_d  = CW'(1);
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         if (do_push & ~do_pop)      count_d = count_q + CW'(1);
         else if (do_pop & ~do_push) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (flush | do_push) mem[wr_ptr_q] <= wdata;
   end

   assign head  = mem[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/cmd_queue.sv
// Command buffer between UART_wrapper and the command processor; exposes the same
// cmd/cmd_rdy/clr_cmd_rdy handshake and lets a flush command preempt queued work.
module cmd_queue
   import cmd_pkg::*;
#(
   parameter  int   DEPTH     = 4,
   parameter  cmd_t FLUSH_CMD = FLUSH_CMD_DEF,
   localparam int   CW        = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [15:0]   uart_cmd,
   input  logic          uart_cmd_rdy,
   output logic          uart_clr_rdy,
   output logic [15:0]   cmd,
   output logic          cmd_rdy,
   input  logic          clr_cmd_rdy,
   output logic [CW-1:0] count,
   output logic          overflow,
   input  logic          ovf_clr
);

   logic          acc_q, acc_d;
   logic          ovf_q, ovf_d;
   logic          accept, is_flush, push, full;
   cmd_t          head;
   logic [CW-1:0] count_w;

   // acc_q masks the cycle where UART_wrapper's cmd_rdy is still falling after a take.
   assign accept   = uart_cmd_rdy & ~acc_q & ~rst;
   assign is_flush = accept & is_cmd(uart_cmd, FLUSH_CMD);
   assign push     = accept & ~is_flush;
   assign full     = (count_w == CW'(DEPTH));

   always_comb begin
      acc_d = accept;
      ovf_d = ovf_q;
      if (ovf_clr)                          ovf_d = 1'b0;
      else if (push & full & ~clr_cmd_rdy) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ovf_q <= ovf_d;
      end
   end

   cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (clr_cmd_rdy),
      .flush (is_flush),
      .wdata (uart_cmd),
      .head  (head),
      .count (count_w)
   );

   assign uart_clr_rdy = accept;
   assign cmd_rdy      = (count_w != '0);
   assign cmd          = cmd_rdy ? head : 16'h0000;
   assign count        = count_w;
   assign overflow     = ovf_q;

endmodule

// File: tb/tb_cmd_queue.sv
// Directed and randomized bench for cmd_queue, checked against a queue-based reference.
module tb_cmd_queue;
   import cmd_pkg::*;

   localparam int   DEPTH = 4;
   localparam int   CW    = $clog2(DEPTH + 1);
   localparam cmd_t FLUSH = 16'h0000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [15:0]   uart_cmd = '0;
   logic          uart_cmd_rdy = 1'b0;
   logic          uart_clr_rdy;
   logic [15:0]   cmd;
   logic          cmd_rdy;
   logic          clr_cmd_rdy = 1'b0;
   logic [CW-1:0] count;
   logic          overflow;
   logic          ovf_clr = 1'b0;

   int   n_checks = 0;
   int   n_errors = 0;

   // Reference: expected queue contents, sticky overflow, and last-cycle take.
   cmd_t sb_q[$];
   logic m_acc = 1'b0;
   logic m_ovf = 1'b0;

   always #5 clk = ~clk;

   cmd_queue #(
      .DEPTH     (DEPTH),
      .FLUSH_CMD (FLUSH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .uart_cmd     (uart_cmd),
      .uart_cmd_rdy (uart_cmd_rdy),
      .uart_clr_rdy (uart_clr_rdy),
      .cmd          (cmd),
      .cmd_rdy      (cmd_rdy),
      .clr_cmd_rdy  (clr_cmd_rdy),
      .count        (count),
      .overflow     (overflow),
      .ovf_clr      (ovf_clr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares DUT outputs to the reference, then advances the reference
   // using the inputs that the coming rising edge will sample.
   always @(negedge clk) begin
      logic exp_acc;
      logic do_pop;
      logic ovf_set;
      if (rst) begin
         sb_q.delete();
         m_acc = 1'b0;
         m_ovf = 1'b0;
         check("rst_count", 32'(count), 32'(0));
         check("rst_cmd_rdy", 32'(cmd_rdy), 32'(0));
         check("rst_cmd", 32'(cmd), 32'(0));
         check("rst_overflow", 32'(overflow), 32'(0));
         check("rst_uart_clr_rdy", 32'(uart_clr_rdy), 32'(0));
      end else begin
         exp_acc = uart_cmd_rdy & ~m_acc;
         check("count", 32'(count), 32'(sb_q.size()));
         check("cmd_rdy", 32'(cmd_rdy), 32'(sb_q.size() != 0));
         check("cmd", 32'(cmd), (sb_q.size() != 0) ? 32'(sb_q[0]) : 32'(0));
         check("overflow", 32'(overflow), 32'(m_ovf));
         check("uart_clr_rdy", 32'(uart_clr_rdy), 32'(exp_acc));
         do_pop  = clr_cmd_rdy && (sb_q.size() > 0);
         ovf_set = 1'b0;
         if (exp_acc && (uart_cmd == FLUSH)) begin
            sb_q.delete();
            sb_q.push_back(FLUSH);
         end else begin
            if (do_pop) begin
               check("pop_head", 32'(cmd), 32'(sb_q[0]));
               void'(sb_q.pop_front());
            end
            if (exp_acc) begin
               if (sb_q.size() < DEPTH) sb_q.push_back(uart_cmd);
               else                     ovf_set = 1'b1;
            end
         end
         if (ovf_clr)      m_ovf = 1'b0;
         else if (ovf_set) m_ovf = 1'b1;
         m_acc = exp_acc;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // UART_wrapper model: hold the word until taken, optionally popping in the first cycle.
   task automatic send(input cmd_t w, input logic pop);
      logic got;
      got          = 1'b0;
      uart_cmd     = w;
      uart_cmd_rdy = 1'b1;
      clr_cmd_rdy  = pop;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = uart_clr_rdy;
         step();
         clr_cmd_rdy = 1'b0;
      end
      uart_cmd_rdy = 1'b0;
      check("uart_take", 32'(got), 32'(1));
      step();
   endtask

   task automatic pop_expect(input cmd_t w);
      check("head_before_pop", 32'(cmd), 32'(w));
      clr_cmd_rdy = 1'b1;
      step();
      clr_cmd_rdy = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   pulses;
      logic got;
      logic busy;
      logic linger;
      logic clr_seen;
      cmd_t pat [3];
      pat[0] = 16'hA5A5;
      pat[1] = 16'h0001;
      pat[2] = 16'h0003;
      busy   = 1'b0;
      linger = 1'b0;

      repeat (3) step();
      rst = 1'b0;
      step();

      // Spaced pushes, then drain in order.
      for (int i = 0; i < 3; i++) begin
         send(pat[i], 1'b0);
         check("t1_count_up", 32'(count), 32'(i + 1));
         check("t1_head", 32'(cmd), 32'(16'hA5A5));
         repeat (8) step();
      end
      for (int i = 0; i < 3; i++) begin
         pop_expect(pat[i]);
         check("t1_count_down", 32'(count), 32'(2 - i));
      end

      // Word lingers one extra cycle after the take: exactly one take.
      pulses       = 0;
      uart_cmd     = 16'h00BB;
      uart_cmd_rdy = 1'b1;
      repeat (2) begin
         @(negedge clk);
         pulses += int'(uart_clr_rdy);
         step();
      end
      uart_cmd_rdy = 1'b0;
      check("t2_pulses", 32'(pulses), 32'(1));
      check("t2_count", 32'(count), 32'(1));
      step();
      pop_expect(16'h00BB);

      // Fill, overflow on a fifth word, then clear the sticky flag.
      for (int i = 1; i <= 4; i++) send(cmd_t'(i), 1'b0);
      check("t3_full", 32'(count), 32'(4));
      send(16'h1234, 1'b0);
      check("t3_count", 32'(count), 32'(4));
      check("t3_overflow", 32'(overflow), 32'(1));
      check("t3_head", 32'(cmd), 32'(16'h0001));
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check("t3_ovf_clr", 32'(overflow), 32'(0));

      // Push into a full queue with a simultaneous pop.
      send(16'h0005, 1'b1);
      check("t4_count", 32'(count), 32'(4));
      check("t4_overflow", 32'(overflow), 32'(0));
      for (int i = 2; i <= 5; i++) pop_expect(cmd_t'(i));
      check("t4_empty", 32'(count), 32'(0));

      // Flush preempts queued entries.
      send(16'h0001, 1'b0);
      send(16'h0003, 1'b0);
      send(FLUSH, 1'b0);
      check("t5_count", 32'(count), 32'(1));
      check("t5_cmd", 32'(cmd), 32'(FLUSH));
      check("t5_cmd_rdy", 32'(cmd_rdy), 32'(1));

      // Build count=3 with overflow set, then reset mid-cycle.
      for (int i = 7; i <= 10; i++) send(cmd_t'(i), 1'b0);
      check("t6_overflow_pre", 32'(overflow), 32'(1));
      pop_expect(FLUSH);
      check("t6_count_pre", 32'(count), 32'(3));
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_count", 32'(count), 32'(0));
      check("t6_rst_cmd_rdy", 32'(cmd_rdy), 32'(0));
      check("t6_rst_cmd", 32'(cmd), 32'(0));
      check("t6_rst_overflow", 32'(overflow), 32'(0));
      step();
      rst          = 1'b0;
      uart_cmd     = 16'h0042;
      uart_cmd_rdy = 1'b1;
      @(negedge clk);
      got = uart_clr_rdy;
      step();
      uart_cmd_rdy = 1'b0;
      check("t6_take_after_rst", 32'(got), 32'(1));
      check("t6_count_after", 32'(count), 32'(1));
      check("t6_cmd_after", 32'(cmd), 32'(16'h0042));
      step();
      pop_expect(16'h0042);

      // Randomized traffic; the monitor checks every cycle.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         clr_seen = uart_clr_rdy;
         step();
         if (linger) begin
            linger = 1'b0;
            busy   = 1'b0;
         end else if (busy && clr_seen) begin
            if ($urandom_range(3) == 0) linger = 1'b1;
            else                        busy   = 1'b0;
         end else if (!busy && ($urandom_range(1) == 0)) begin
            busy     = 1'b1;
            uart_cmd = ($urandom_range(7) == 0) ? FLUSH : cmd_t'($urandom_range(65535, 1));
         end
         uart_cmd_rdy = busy;
         clr_cmd_rdy  = ($urandom_range(3) == 0);
         ovf_clr      = ($urandom_range(31) == 0);
      end
      uart_cmd_rdy = 1'b0;
      clr_cmd_rdy  = 1'b0;
      ovf_clr      = 1'b0;
      repeat (4) step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
